// File: rtl/pulse_dec_2_4_v_pkg.sv
// Shared definitions for the pulse-stretching 2-to-4 decoder.
// Holds the FSM state encoding, the counter width and the one-hot mapping helper.
package pulse_dec_2_4_v_pkg;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Inverse of the 4-to-2 priority encoder: code n selects line n.
  function automatic logic [3:0] code_to_line(input logic [1:0] code);
    logic [3:0] line;
    line = '0;
    unique case (code)
      2'b00: line = 4'b0001;
      2'b01: line = 4'b0010;
      2'b10: line = 4'b0100;
      2'b11: line = 4'b1000;
      default: line = '0;
    endcase
    return line;
  endfunction

endpackage

// File: rtl/pulse_dec_2_4_v_dec.sv
// Combinational 2-to-4 one-hot decoder; the parent registers its output.
module dec_2_4_v
  import pulse_dec_2_4_v_pkg::*;
(
  input  logic [1:0] code,
  output logic [3:0] line
);

  always_comb begin
    line = code_to_line(code);
  end

endmodule

// File: rtl/pulse_dec_2_4_v.sv
// Decodes an accepted 2-bit code into a one-hot line held for PULSE_LEN cycles,
// followed by GAP_LEN enforced idle cycles. One FSM and one shared down-counter.
module pulse_dec_2_4_v
  import pulse_dec_2_4_v_pkg::*;
#(
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned GAP_LEN   = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_code,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [3:0] o_line,
  output logic       o_busy,
  output logic       o_done
);

  if (PULSE_LEN < 1 || PULSE_LEN > CNT_MAX) begin : g_bad_pulse_len
    $error("pulse_dec_2_4_v: PULSE_LEN must be in 1..255");
  end
  if (GAP_LEN > CNT_MAX) begin : g_bad_gap_len
    $error("pulse_dec_2_4_v: GAP_LEN must be in 0..255");
  end

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_LEN == 0) ? 0 : GAP_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       dec_line;

  dec_2_4_v u_dec (
    .code (i_code),
    .line (dec_line)
  );

  // Ready/busy come straight from the state register, so i_valid never feeds o_ready.
  assign o_ready = (state == ST_IDLE);
  assign o_busy  = (state != ST_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      o_line <= '0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (i_valid) begin
            state  <= ST_PULSE;
            o_line <= dec_line;
            cnt    <= PULSE_LOAD;
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            o_line <= '0;
            o_done <= 1'b1;
            if (GAP_LEN > 0) begin
              state <= ST_GAP;
              cnt   <= GAP_LOAD;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_GAP: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          o_line <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_dec_2_4_v.sv
// Directed bench for pulse_dec_2_4_v: three instances cover PULSE_LEN/GAP_LEN
// combinations (4/2, 4/0, 1/1) driven from shared stimulus.
module tb_pulse_dec_2_4_v;

  logic       clk;
  logic       rst;
  logic [1:0] code;
  logic       valid;

  logic       ready_a, busy_a, done_a;
  logic [3:0] line_a;
  logic       ready_b, busy_b, done_b;
  logic [3:0] line_b;
  logic       ready_c, busy_c, done_c;
  logic [3:0] line_c;

  int total = 0;
  int bad   = 0;

  pulse_dec_2_4_v #(.PULSE_LEN(4), .GAP_LEN(2)) u_a (
    .i_clk(clk), .i_rst(rst), .i_code(code), .i_valid(valid),
    .o_ready(ready_a), .o_line(line_a), .o_busy(busy_a), .o_done(done_a)
  );

  pulse_dec_2_4_v #(.PULSE_LEN(4), .GAP_LEN(0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_code(code), .i_valid(valid),
    .o_ready(ready_b), .o_line(line_b), .o_busy(busy_b), .o_done(done_b)
  );

  pulse_dec_2_4_v #(.PULSE_LEN(1), .GAP_LEN(1)) u_c (
    .i_clk(clk), .i_rst(rst), .i_code(code), .i_valid(valid),
    .o_ready(ready_c), .o_line(line_c), .o_busy(busy_c), .o_done(done_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    valid = 1'b0;
    code  = 2'b00;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    valid = 1'b1;
    code  = 2'b11;
    tick();
    total++;
    if (line_a !== 4'b0000 || done_a !== 1'b0 || busy_a !== 1'b0 || ready_a !== 1'b1) begin
      bad++;
      $display("FAIL reset_a: line=%b done=%b busy=%b ready=%b, want 0000 0 0 1",
               line_a, done_a, busy_a, ready_a);
    end
    total++;
    if (line_b !== 4'b0000 || done_b !== 1'b0 || busy_b !== 1'b0 || ready_b !== 1'b1) begin
      bad++;
      $display("FAIL reset_b: line=%b done=%b busy=%b ready=%b, want 0000 0 0 1",
               line_b, done_b, busy_b, ready_b);
    end
    total++;
    if (line_c !== 4'b0000 || done_c !== 1'b0 || busy_c !== 1'b0 || ready_c !== 1'b1) begin
      bad++;
      $display("FAIL reset_c: line=%b done=%b busy=%b ready=%b, want 0000 0 0 1",
               line_c, done_c, busy_c, ready_c);
    end
    rst   = 1'b0;
    valid = 1'b0;
    tick();
    total++;
    if (line_a !== 4'b0000 || busy_a !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid_ignored: line=%b busy=%b, want 0000 0", line_a, busy_a);
    end
  endtask

  task automatic test_basic();
    logic [3:0] exp_line;
    do_reset();
    valid = 1'b1;
    code  = 2'b10;
    tick();
    valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      exp_line = (c <= 4) ? 4'b0100 : 4'b0000;
      total++;
      if (line_a !== exp_line || done_a !== (c == 5) || ready_a !== (c >= 7) || busy_a !== (c <= 6)) begin
        bad++;
        $display("FAIL basic cycle %0d: line=%b done=%b ready=%b busy=%b, want %b %b %b %b",
                 c, line_a, done_a, ready_a, busy_a, exp_line, (c == 5), (c >= 7), (c <= 6));
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_line;
    logic       exp_flag;
    do_reset();
    valid = 1'b1;
    code  = 2'b00;
    tick();
    code = 2'b11;
    for (int c = 1; c <= 10; c++) begin
      if (c <= 4)      exp_line = 4'b0001;
      else if (c == 5) exp_line = 4'b0000;
      else if (c <= 9) exp_line = 4'b1000;
      else             exp_line = 4'b0000;
      exp_flag = (c == 5) || (c == 10);
      total++;
      if (line_b !== exp_line || done_b !== exp_flag || ready_b !== exp_flag) begin
        bad++;
        $display("FAIL back_to_back cycle %0d: line=%b done=%b ready=%b, want %b %b %b",
                 c, line_b, done_b, ready_b, exp_line, exp_flag, exp_flag);
      end
      if (c == 6) valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_ignore_busy();
    logic [3:0] exp_line;
    do_reset();
    valid = 1'b1;
    code  = 2'b00;
    tick();
    valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      exp_line = (c <= 4) ? 4'b0001 : 4'b0000;
      total++;
      if (line_a !== exp_line || done_a !== (c == 5) || ready_a !== (c >= 7)) begin
        bad++;
        $display("FAIL ignore_busy cycle %0d: line=%b done=%b ready=%b, want %b %b %b",
                 c, line_a, done_a, ready_a, exp_line, (c == 5), (c >= 7));
      end
      if (c == 2) begin
        valid = 1'b1;
        code  = 2'b01;
      end
      if (c == 3) valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    // Reset during the second PULSE cycle.
    do_reset();
    valid = 1'b1;
    code  = 2'b11;
    tick();
    valid = 1'b0;
    tick();
    total++;
    if (line_a !== 4'b1000) begin
      bad++;
      $display("FAIL reset_mid_pre: line=%b, want 1000", line_a);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (line_a !== 4'b0000 || ready_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_pulse: line=%b ready=%b busy=%b done=%b, want 0000 1 0 0",
               line_a, ready_a, busy_a, done_a);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (done_a !== 1'b0 || line_a !== 4'b0000) begin
        bad++;
        $display("FAIL reset_mid_pulse_quiet %0d: done=%b line=%b, want 0 0000", c, done_a, line_a);
      end
    end
    // Reset during the first GAP cycle.
    valid = 1'b1;
    code  = 2'b01;
    tick();
    valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    total++;
    if (done_a !== 1'b1 || busy_a !== 1'b1 || line_a !== 4'b0000) begin
      bad++;
      $display("FAIL reset_mid_gap_pre: done=%b busy=%b line=%b, want 1 1 0000", done_a, busy_a, line_a);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (ready_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 || line_a !== 4'b0000) begin
      bad++;
      $display("FAIL reset_mid_gap: ready=%b busy=%b done=%b line=%b, want 1 0 0 0000",
               ready_a, busy_a, done_a, line_a);
    end
  endtask

  task automatic test_pulse_len_1();
    logic [3:0] exp_line;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      valid = 1'b1;
      code  = 2'(k);
      tick();
      valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        exp_line = (c == 1) ? (4'b0001 << k) : 4'b0000;
        total++;
        if (line_c !== exp_line || done_c !== (c == 2) || ready_c !== (c == 3)) begin
          bad++;
          $display("FAIL pulse_len_1 code %0d cycle %0d: line=%b done=%b ready=%b, want %b %b %b",
                   k, c, line_c, done_c, ready_c, exp_line, (c == 2), (c == 3));
        end
        total++;
        if (!$onehot0(line_c)) begin
          bad++;
          $display("FAIL onehot0 code %0d cycle %0d: line=%b, want at most one bit set", k, c, line_c);
        end
        if (c < 3) tick();
      end
    end
  endtask

  task automatic test_loopback();
    logic [3:0] in_vec;
    logic [3:0] exp_line;
    logic [1:0] enc;
    do_reset();
    for (int v = 1; v < 16; v++) begin
      in_vec = 4'(v);
      enc    = 2'b00;
      for (int b = 3; b >= 0; b--) begin
        if (in_vec[b]) enc = 2'(b);
      end
      exp_line = in_vec & (~in_vec + 4'd1);
      valid = 1'b1;
      code  = enc;
      tick();
      valid = 1'b0;
      total++;
      if (line_a !== exp_line) begin
        bad++;
        $display("FAIL loopback in=%b: line=%b, want %b", in_vec, line_a, exp_line);
      end
      for (int c = 0; c < 6; c++) tick();
      total++;
      if (ready_a !== 1'b1) begin
        bad++;
        $display("FAIL loopback_ready in=%b: ready=%b, want 1", in_vec, ready_a);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    code  = 2'b00;
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_pulse_len_1();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_dec_2_4_v.md
PULSE_DEC_2_4_V -- requirements
Module: pulse_dec_2_4_v

Interface
REQ-001 Parameter PULSE_LEN, default 4, is the number of cycles a decoded line stays high; legal range 1..255.
REQ-002 Parameter GAP_LEN, default 1, is the number of idle cycles enforced after a pulse; legal range 0..255.
REQ-003 Port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port i_code, input, 2 bits: encoded line index; 0 = line 0.
REQ-006 Port i_valid, input, 1 bit: i_code is valid this cycle.
REQ-007 Port o_ready, output, 1 bit: block can accept a code this cycle.
REQ-008 Port o_line, output, 4 bits: one-hot decoded line, registered.
REQ-009 Port o_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 Port o_done, output, 1 bit: one-cycle strobe marking the end of a pulse.

Function
REQ-011 Acceptance SHALL occur on a rising edge where i_valid=1 and o_ready=1; i_code is captured on that edge.
REQ-012 o_ready SHALL be 1 only in IDLE and SHALL be decoded from state only, with no combinational path from i_valid.
REQ-013 i_valid while o_ready=0 SHALL be ignored; no buffering, no error flag.
REQ-014 FSM states: IDLE, PULSE, GAP.
REQ-015 IDLE -> PULSE on acceptance: o_line = 1 << captured code; down-counter loads PULSE_LEN-1.
REQ-016 In PULSE the counter SHALL decrement each cycle; on the cycle the counter reads 0, the next edge clears o_line and moves to GAP if GAP_LEN>0, else to IDLE.
REQ-017 In GAP the counter SHALL be loaded with GAP_LEN-1 on entry and decrement; at 0 the next edge moves to IDLE.
REQ-018 o_line SHALL be high for exactly PULSE_LEN cycles, starting the cycle after acceptance (latency 1).
REQ-019 o_line SHALL be all-zero outside PULSE and exactly one-hot inside PULSE.
REQ-020 o_done SHALL be high for exactly the one cycle immediately after the last o_line-high cycle.
REQ-021 With GAP_LEN=0, o_done and o_ready SHALL both be high in the same cycle, and a new acceptance in that cycle SHALL be legal (back-to-back pulses separated by one idle cycle).
REQ-022 Pulse-to-acceptance period SHALL be PULSE_LEN+GAP_LEN+1 cycles minimum.
REQ-023 The counter width SHALL be 8 bits, and the counter SHALL never wrap: it is loaded before any decrement below 0.
REQ-024 PULSE_LEN=0 or either parameter >255 SHALL fail elaboration.
REQ-025 Code mapping SHALL be the inverse of the team's 4-to-2 priority encoder: 2'b00->0001, 2'b01->0010, 2'b10->0100, 2'b11->1000.

Reset
REQ-026 When i_rst=1 at a rising edge, the block SHALL enter IDLE, and reset SHALL take priority over every simultaneous event.
REQ-027 Reset values: o_line=0000, o_done=0, o_busy=0, counter=0, o_ready=1 from the first cycle after the reset edge.
REQ-028 Reset mid-PULSE or mid-GAP SHALL clear o_line on that edge and SHALL emit no o_done.
REQ-029 An i_valid coincident with i_rst SHALL not be accepted.

Structure
REQ-030 State encodings (IDLE/PULSE/GAP) and the counter width constant SHALL live in the shared datapath-components package/include.
REQ-031 One sub-module SHALL be used: dec_2_4_v, a combinational 2-to-4 one-hot decoder whose output is registered into o_line by the parent.
REQ-032 The implementation SHALL be a single FSM plus one shared down-counter.

Verification
REQ-033 PULSE_LEN=4, GAP_LEN=2, accept code 2'b10 at cycle 0 -> o_line=0100 in cycles 1-4, o_done in cycle 5, o_ready=0 in cycles 1-6, o_ready=1 in cycle 7.
REQ-034 GAP_LEN=0, i_valid held high with codes 0,3 -> o_line=0001 for PULSE_LEN cycles, one zero cycle with o_done=1, then o_line=1000.
REQ-035 i_valid pulsed with code 1 during PULSE of code 0 -> ignored; only o_line=0001 is seen, and no second pulse occurs.
REQ-036 Assert i_rst in the 2nd PULSE cycle -> o_line=0000 and o_ready=1 the next cycle, o_done never asserted.
REQ-037 All 4 codes, PULSE_LEN=1 -> each line high for exactly 1 cycle; $onehot0(o_line) assertion holds on every cycle.
REQ-038 Loopback from the priority encoder for all 16 inputs with o_valid=1 -> o_line equals the lowest set bit of the input.
